// File: rtl/uart_stream_pkg.sv
// Shared types and helpers for the buffered UART stream link.
// Used by uart_stream_link and sync_fifo.
package uart_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // One extra MSB distinguishes full from empty when the index bits match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
// rd_data reads as zero while the FIFO is empty.
module sync_fifo
  import uart_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_stream_link.sv
// Buffered UART transceiver: serial pins to valid/ready byte streams.
// Define UART_STREAM_PARITY_EN to add an even-parity bit in both directions.
module uart_stream_link
  import uart_stream_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_parity_err
);

  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS);
`ifdef UART_STREAM_PARITY_EN
  localparam uart_state_t AFTER_DATA = PARITY;
`else
  localparam uart_state_t AFTER_DATA = STOP;
`endif

  // ---------------- RX ----------------
  logic                 rx_s1, rx_s2, rx_prev;
  uart_state_t          rx_state, rx_next;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_tick, rx_fall, rx_par_bad, rx_push, rx_full, rx_empty;

  assign rx_tick = (rx_cnt == CW'(1));
  assign rx_fall = rx_prev && !rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rx_state <= IDLE;
    else     rx_state <= rx_next;
  end

  // A frame error returns to IDLE while the line is still low; IDLE only
  // re-arms on a fresh falling edge, so it waits for the line to go high.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      IDLE:    if (rx_fall) rx_next = START;
      START:   if (rx_tick) rx_next = rx_s2 ? IDLE : DATA;
      DATA:    if (rx_tick && rx_bit == BW'(DATA_BITS - 1)) rx_next = AFTER_DATA;
      PARITY:  if (rx_tick) rx_next = STOP;
      STOP:    if (rx_tick) rx_next = IDLE;
      default: rx_next = IDLE;
    endcase
  end

`ifdef UART_STREAM_PARITY_EN
  logic rx_par;
  assign rx_par_bad = (rx_par != ^rx_shift);
`else
  assign rx_par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
`ifdef UART_STREAM_PARITY_EN
      rx_par   <= 1'b0;
`endif
    end else if (rx_state == IDLE) begin
      rx_cnt <= CW'(CLKS_PER_BIT / 2);
      rx_bit <= '0;
    end else if (rx_tick) begin
      rx_cnt <= CW'(CLKS_PER_BIT);
      if (rx_state == DATA) begin
        rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
        rx_bit   <= rx_bit + BW'(1);
      end
`ifdef UART_STREAM_PARITY_EN
      if (rx_state == PARITY) rx_par <= rx_s2;
`endif
    end else begin
      rx_cnt <= rx_cnt - CW'(1);
    end
  end

  always_comb begin
    rx_push       = 1'b0;
    rx_frame_err  = 1'b0;
    rx_parity_err = 1'b0;
    if (rx_state == STOP && rx_tick) begin
      if (!rx_s2)          rx_frame_err  = 1'b1;
      else if (rx_par_bad) rx_parity_err = 1'b1;
      else                 rx_push       = 1'b1;
    end
    rx_overrun = rx_push && rx_full;
  end

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (rx_push),
    .wr_data (rx_shift),
    .pop     (rx_valid && rx_ready),
    .rd_data (rx_data),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  assign rx_valid = !rx_empty;

  // ---------------- TX ----------------
  uart_state_t          tx_state, tx_next;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift, tx_head;
  logic                 tx_done, tx_pop, tx_full, tx_empty;

  assign tx_done = (tx_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) tx_state <= IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      IDLE:    if (!tx_empty) tx_next = START;
      START:   if (tx_done) tx_next = DATA;
      DATA:    if (tx_done && tx_bit == BW'(DATA_BITS - 1)) tx_next = AFTER_DATA;
      PARITY:  if (tx_done) tx_next = STOP;
      STOP:    if (tx_done) tx_next = tx_empty ? IDLE : START;
      default: tx_next = IDLE;
    endcase
  end

`ifdef UART_STREAM_PARITY_EN
  logic tx_par;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
`ifdef UART_STREAM_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_shift <= tx_head;
      tx_cnt   <= CW'(CLKS_PER_BIT - 1);
      tx_bit   <= '0;
`ifdef UART_STREAM_PARITY_EN
      tx_par   <= ^tx_head;
`endif
    end else if (tx_state != IDLE) begin
      if (tx_done) begin
        tx_cnt <= (tx_next == STOP) ? CW'(STOP_BITS * CLKS_PER_BIT - 1) : CW'(CLKS_PER_BIT - 1);
        if (tx_state == DATA) begin
          tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
          tx_bit   <= tx_bit + BW'(1);
        end
      end else begin
        tx_cnt <= tx_cnt - CW'(1);
      end
    end
  end

  // Popping at the end of STOP starts the next frame with no idle gap.
  always_comb begin
    tx_pop  = 1'b0;
    uart_tx = 1'b1;
    case (tx_state)
      IDLE:    tx_pop = !tx_empty;
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = tx_shift[0];
`ifdef UART_STREAM_PARITY_EN
      PARITY:  uart_tx = tx_par;
`endif
      STOP:    tx_pop = tx_done && !tx_empty;
      default: uart_tx = 1'b1;
    endcase
  end

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tx_valid && tx_ready),
    .wr_data (tx_data),
    .pop     (tx_pop),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  assign tx_ready = !tx_full;
  assign tx_busy  = (tx_state != IDLE) || !tx_empty;

endmodule

// File: tb/tb_uart_stream_link.sv
// Self-checking bench for uart_stream_link (CLKS_PER_BIT=4, 8N1, depth 16).
// Also valid with UART_STREAM_PARITY_EN defined.
module tb_uart_stream_link;

  localparam int CPB   = 4;
  localparam int DB    = 8;
  localparam int SB    = 1;
  localparam int DEPTH = 16;
`ifdef UART_STREAM_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = 1 + DB + PB + SB;

  logic          clk = 1'b0;
  logic          rst;
  logic          uart_rx;
  logic          uart_tx;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [DB-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_busy;
  logic          rx_frame_err;
  logic          rx_overrun;
  logic          rx_parity_err;

  uart_stream_link #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .STOP_BITS    (SB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .uart_rx       (uart_rx),
    .uart_tx       (uart_tx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_busy       (tx_busy),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun),
    .rx_parity_err (rx_parity_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_ferr = 0, n_ovr = 0, n_perr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_frame_err  === 1'b1) n_ferr++;
    if (rx_overrun    === 1'b1) n_ovr++;
    if (rx_parity_err === 1'b1) n_perr++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- RX stimulus ----------------
  task automatic rx_bit(input logic b);
    uart_rx = b;
    tick(CPB);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_v, input logic par_good);
    rx_bit(1'b0);
    for (int i = 0; i < DB; i++) rx_bit(d[i]);
`ifdef UART_STREAM_PARITY_EN
    rx_bit(par_good ? ^d : ~^d);
`endif
    rx_bit(stop_v);
    uart_rx = 1'b1;
    tick(3 * CPB);
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par_good;
    logic       exp_push;
    int         exp_ferr;
    int         exp_perr;
  } rx_vec_t;

  task automatic apply_rx(input rx_vec_t v);
    int f0, p0, o0;
    f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
    send_rx(v.data, v.stop, v.par_good);
    check($sformatf("rx_ferr[%02h]", v.data), n_ferr - f0, v.exp_ferr);
    check($sformatf("rx_perr[%02h]", v.data), n_perr - p0, v.exp_perr);
    check($sformatf("rx_ovr[%02h]", v.data), n_ovr - o0, 0);
    check($sformatf("rx_valid[%02h]", v.data), rx_valid, v.exp_push);
    if (v.exp_push) check($sformatf("rx_data[%02h]", v.data), rx_data, v.data);
    if (rx_valid) pop_rx();
  endtask

  // Reference expectations straight from the frame rules.
  function automatic rx_vec_t rx_model(input logic [7:0] d, input logic stop_v, input logic pg);
    rx_vec_t v;
    v.data     = d;
    v.stop     = stop_v;
    v.par_good = pg;
    v.exp_ferr = stop_v ? 0 : 1;
    v.exp_perr = (stop_v && PB == 1 && !pg) ? 1 : 0;
    v.exp_push = stop_v && !(PB == 1 && !pg);
    return v;
  endfunction

  // ---------------- TX monitor / stimulus ----------------
  logic [7:0] tx_got[$];
  int         tx_start[$];
  logic [7:0] tx_exp[$];
  int         tx_frame_bad = 0;
  logic       tx_last_par = 1'b0;

  initial begin
    logic [7:0] d;
    int st;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && uart_tx === 1'b0) begin
        st = cyc;
        repeat (CPB / 2) @(negedge clk);
        if (uart_tx !== 1'b0) tx_frame_bad++;
        for (int i = 0; i < DB; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = uart_tx;
        end
`ifdef UART_STREAM_PARITY_EN
        repeat (CPB) @(negedge clk);
        tx_last_par = uart_tx;
`endif
        for (int s = 0; s < SB; s++) begin
          repeat (CPB) @(negedge clk);
          if (uart_tx !== 1'b1) tx_frame_bad++;
        end
        tx_got.push_back(d);
        tx_start.push_back(st);
      end
    end
  end

  task automatic push_tx(input logic [7:0] d);
    logic acc;
    acc = 1'b0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int k = 0; k < 400 && !acc; k++) begin
      acc = tx_ready;
      tick(1);
    end
    tx_valid = 1'b0;
    check("tx_push_accepted", acc, 1'b1);
    if (acc) tx_exp.push_back(d);
  endtask

  task automatic wait_tx_idle(input int budget, output int fall_cyc);
    fall_cyc = -1;
    for (int k = 0; k < budget; k++) begin
      if (!tx_busy) begin
        fall_cyc = cyc;
        break;
      end
      tick(1);
    end
    check("tx_idle_in_budget", (fall_cyc >= 0), 1'b1);
  endtask

  function automatic logic [31:0] q_byte(input int idx);
    if (idx < tx_got.size()) return 32'(tx_got[idx]);
    return 32'hDEAD;
  endfunction

  function automatic int q_start(input int idx);
    if (idx < tx_start.size()) return tx_start[idx];
    return -100000;
  endfunction

  rx_vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fall, e0, o0, n;
    rx_vec_t v;

    rst = 1'b1; uart_rx = 1'b1; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_err_pulses", n_ferr + n_ovr + n_perr, 0);

    // Directed RX vectors: {data, stop, parity_good, push, ferr, perr}.
    vecs.push_back('{8'hA5, 1'b1, 1'b1, 1'b1, 0, 0});
    vecs.push_back('{8'h00, 1'b1, 1'b1, 1'b1, 0, 0});
    vecs.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 0, 0});
    vecs.push_back('{8'h3C, 1'b0, 1'b1, 1'b0, 1, 0});
    vecs.push_back('{8'h55, 1'b1, 1'b1, 1'b1, 0, 0});
    vecs.push_back('{8'h80, 1'b0, 1'b1, 1'b0, 1, 0});
    vecs.push_back('{8'h01, 1'b1, 1'b1, 1'b1, 0, 0});
`ifdef UART_STREAM_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b0, 0, 1});
    vecs.push_back('{8'h07, 1'b0, 1'b0, 1'b0, 1, 0});
    vecs.push_back('{8'h07, 1'b1, 1'b1, 1'b1, 0, 0});
`endif
    foreach (vecs[i]) apply_rx(vecs[i]);

    // Randomized RX frames checked against rx_model.
    for (int i = 0; i < 12; i++) begin
      v = rx_model(8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      apply_rx(v);
    end

    // Overrun: 17 bytes with rx_ready held low, then drain.
    o0 = n_ovr;
    for (int b = 0; b < DEPTH; b++) send_rx(8'(b), 1'b1, 1'b1);
    check("ovr_before_full", n_ovr - o0, 0);
    send_rx(8'(DEPTH), 1'b1, 1'b1);
    check("ovr_on_byte_10", n_ovr - o0, 1);
    for (int b = 0; b < DEPTH; b++) begin
      check($sformatf("drain_valid[%0d]", b), rx_valid, 1'b1);
      check($sformatf("drain_data[%0d]", b), rx_data, 32'(b));
      pop_rx();
    end
    check("drain_empty", rx_valid, 1'b0);

    // Two back-to-back TX frames.
    tx_got.delete(); tx_start.delete(); tx_exp.delete();
    push_tx(8'h3C);
    push_tx(8'hFF);
    wait_tx_idle(4 * FRAME * CPB, fall);
    check("tx2_count", tx_got.size(), 2);
    check("tx2_byte0", q_byte(0), 8'h3C);
    check("tx2_byte1", q_byte(1), 8'hFF);
    check("tx2_no_gap", q_start(1) - q_start(0), FRAME * CPB);
    check("tx2_busy_fall", fall - q_start(0), 2 * FRAME * CPB);
    check("tx2_line_idle", uart_tx, 1'b1);

    // Random TX burst large enough to hit backpressure.
    tx_got.delete(); tx_start.delete(); tx_exp.delete();
    n = 24;
    for (int i = 0; i < n; i++) begin
      push_tx(8'($urandom));
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 6));
    end
    wait_tx_idle((n + 2) * FRAME * CPB, fall);
    check("txr_count", tx_got.size(), tx_exp.size());
    foreach (tx_exp[i]) check($sformatf("txr_byte[%0d]", i), q_byte(i), tx_exp[i]);
    check("tx_frame_shape", tx_frame_bad, 0);

`ifdef UART_STREAM_PARITY_EN
    tx_got.delete(); tx_start.delete(); tx_exp.delete();
    push_tx(8'h07);
    wait_tx_idle(3 * FRAME * CPB, fall);
    check("txp_byte", q_byte(0), 8'h07);
    check("txp_parity_bit", tx_last_par, 1'b1);
`endif

    // One-cycle glitch, then reset in the middle of a TX frame.
    e0 = n_ferr + n_perr + n_ovr;
    uart_rx = 1'b0;
    tick(1);
    uart_rx = 1'b1;
    tick(3 * CPB);
    check("glitch_no_byte", rx_valid, 1'b0);
    check("glitch_no_err", n_ferr + n_perr + n_ovr - e0, 0);
    push_tx(8'h81);
    tick(15);
    check("mid_frame_busy", tx_busy, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst2_uart_tx", uart_tx, 1'b1);
    check("rst2_tx_ready", tx_ready, 1'b1);
    check("rst2_tx_busy", tx_busy, 1'b0);
    check("rst2_rx_valid", rx_valid, 1'b0);
    tick(2 * FRAME * CPB);
    check("rst2_line_stays_idle", uart_tx, 1'b1);
    check("rst2_rx_still_empty", rx_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_stream_link.md
Name: uart_stream_link

Overview:
- Parametrised, buffered UART transceiver; successor to the fixed UART front end that feeds the SHA-256 processor.
- Converts the serial `uart_rx`/`uart_tx` pins into valid/ready byte streams, with one FIFO per direction.
- Flags framing, overrun and (optional) parity errors.
- Sits between the chip-level pin wrapper and the hash command/packing logic.

Parameters:
- CLKS_PER_BIT, 104: clock cycles per UART bit; must be ≥ 4.
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- STOP_BITS, 1: stop bits transmitted, 1 or 2. RX checks only the first stop bit.
- FIFO_DEPTH, 16: entries per FIFO; must be a power of 2 and ≥ 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- uart_rx  in  1  serial input, asynchronous to clk
- uart_tx  out  1  serial output, idle high
- rx_data  out  DATA_BITS  head of RX FIFO
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  consumer accepts rx_data
- tx_data  in  DATA_BITS  byte to send
- tx_valid  in  1  producer offers tx_data
- tx_ready  out  1  TX FIFO not full
- tx_busy  out  1  TX FSM not idle, or TX FIFO not empty
- rx_frame_err  out  1  one-cycle pulse: bad stop bit
- rx_overrun  out  1  one-cycle pulse: byte lost because RX FIFO was full
- rx_parity_err  out  1  one-cycle pulse: parity mismatch (tied 0 without the optional feature)

Behaviour:
- Reset is synchronous on rst=1 and may occur mid-frame. All state clears:
  - FIFOs empty, FSMs idle.
  - uart_tx=1, rx_valid=0, tx_ready=1, tx_busy=0, all error pulses 0, rx_data=0.
  - A frame in progress is abandoned; the partially received or sent byte is lost.
- uart_rx passes through a 2-flop synchronizer. All RX decisions use the synchronized signal (2-cycle input latency).
- RX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a falling edge (sync high → low) loads the bit counter with CLKS_PER_BIT/2 and enters START.
  - START: at the mid-bit sample, line still low → DATA. Line high → glitch, return to IDLE with nothing pushed.
  - DATA: samples every CLKS_PER_BIT cycles, LSB first, DATA_BITS samples.
  - STOP: samples the line.
    - High: push the byte into the RX FIFO on the same cycle.
    - Low: pulse rx_frame_err, discard the byte, and wait for the line to return high before re-arming IDLE.
- RX push while FIFO full: byte dropped and rx_overrun pulses. FIFO contents are unchanged.
- RX handshake:
  - Pop on rx_valid && rx_ready.
  - rx_data is stable while rx_valid && !rx_ready.
  - FIFO read is first-word-fall-through: rx_valid rises the cycle after the push.
- TX handshake: push on tx_valid && tx_ready. A push and a pop in the same cycle on a full FIFO is not allowed, because tx_ready=0 blocks the push.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE with FIFO non-empty: pop the byte into the shift register and drive uart_tx=0 on the next cycle.
  - START: each state lasts exactly CLKS_PER_BIT cycles.
  - DATA: LSB first.
  - STOP: high for STOP_BITS×CLKS_PER_BIT cycles.
  - Back-to-back bytes: the next start bit follows the last stop bit with no idle gap.
- Each FIFO has simultaneous push and pop allowed; occupancy is unchanged when both occur.
- Read/write pointers are log2(FIFO_DEPTH)+1 bits:
  - full when the MSBs differ and the remaining bits are equal;
  - empty when the pointers are equal;
  - pointers wrap naturally.

Optional Feature:
- Macro UART_STREAM_PARITY_EN.
- Defined:
  - TX inserts an even-parity bit between the data bits and the stop bit(s).
  - RX samples the parity bit. On mismatch it pulses rx_parity_err and discards the byte. Frame error takes precedence when both occur.
- Undefined: no parity bit in either direction; rx_parity_err is held 0.

Decomposition:
- Shared package uart_stream_pkg:
  - rx/tx state enum (IDLE, START, DATA, PARITY, STOP);
  - pointer-width function (clog2+1).
- One natural sub-module, sync_fifo (parametrised WIDTH, DEPTH), instantiated twice.
- RX/TX FSMs are inline in uart_stream_link.

Test Plan:
1. CLKS_PER_BIT=4. Drive 0xA5 on uart_rx (start, 1,0,1,0,0,1,0,1, stop) → rx_valid asserts, rx_data=0xA5, no error pulses.
2. Push 0x3C, 0xFF via tx_valid → uart_tx shows two back-to-back frames, each 10×4 cycles, LSB first, no gap; tx_busy drops after the last stop.
3. Hold rx_ready=0 and receive 17 bytes 0x00..0x10 with FIFO_DEPTH=16 → exactly one rx_overrun pulse on byte 0x10; draining yields 0x00..0x0F in order.
4. Receive a frame with stop bit low → rx_frame_err pulses once, rx_valid stays 0. A following good 0x55 is received correctly.
5. A 1-cycle low glitch on uart_rx, then assert rst mid-TX-frame → no byte received from the glitch; after rst, uart_tx=1, tx_ready=1, rx_valid=0.
6. With UART_STREAM_PARITY_EN defined, receive 0x07 with parity bit 0 → rx_parity_err pulses and the byte is dropped. Send 0x07 → TX parity bit = 1.
